// File: rtl/mux_skid_stage_if.sv
// Handshake bundle for mux_skid_stage: upstream offer, downstream result and flush.
// master = environment driving the stage, slave = the stage itself.
interface mux_skid_stage_if #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 2
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic                    in_valid;
    logic                    in_ready;
    logic [SEL_W-1:0]        in_sel;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic                    flush;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    sel_err;

    modport master (
        output in_valid, in_sel, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_sel, sel_err
    );

    modport slave (
        input  in_valid, in_sel, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_sel, sel_err
    );
endinterface

// File: rtl/mux_skid_stage.sv
// Registered N-input select stage with valid/ready handshake and two-entry skid buffer.
// Optional out-of-range select checking is enabled by defining MUX_SKID_SEL_CHECK_EN.
module mux_skid_stage #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_skid_stage_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_IN);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] main_data_r;
    logic [SEL_W-1:0] main_sel_r;
    logic [WIDTH-1:0] skid_data_r;
    logic [SEL_W-1:0] skid_sel_r;
    logic             out_valid_r;
    logic             in_ready_r;

    logic             accept_s;
    logic             emit_s;
    logic [SEL_W:0]   sel_ext_s;
    logic             oor_s;
    logic [WIDTH-1:0] sel_data_s;

    assign accept_s  = bus.in_valid && in_ready_r;
    assign emit_s    = out_valid_r && bus.out_ready;
    // Zero-extended compare so a power-of-two NUM_IN never wraps the bound.
    assign sel_ext_s = {1'b0, bus.in_sel};
    assign oor_s     = (sel_ext_s >= (SEL_W+1)'(NUM_IN));

    // AND-OR channel select; out-of-range falls back to zero or channel 0.
    always_comb begin
        sel_data_s = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            sel_data_s = sel_data_s |
                         (bus.in_data[k*WIDTH +: WIDTH] & {WIDTH{sel_ext_s == (SEL_W+1)'(k)}});
        end
`ifndef MUX_SKID_SEL_CHECK_EN
        sel_data_s = sel_data_s | (bus.in_data[WIDTH-1:0] & {WIDTH{oor_s}});
`endif
    end

    // Occupancy FSM: main entry drives outputs, skid absorbs the one in-flight extra.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_EMPTY;
            main_data_r <= '0;
            main_sel_r  <= '0;
            skid_data_r <= '0;
            skid_sel_r  <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (bus.flush) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_data_r <= sel_data_s;
                        main_sel_r  <= bus.in_sel;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept_s && emit_s) begin
                        main_data_r <= sel_data_s;
                        main_sel_r  <= bus.in_sel;
                    end else if (accept_s) begin
                        skid_data_r <= sel_data_s;
                        skid_sel_r  <= bus.in_sel;
                        in_ready_r  <= 1'b0;
                        state_r     <= ST_FULL;
                    end else if (emit_s) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (emit_s) begin
                        main_data_r <= skid_data_r;
                        main_sel_r  <= skid_sel_r;
                        in_ready_r  <= 1'b1;
                        state_r     <= ST_ONE;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

`ifdef MUX_SKID_SEL_CHECK_EN
    logic sel_err_r;

    // Sticky error on any kept accept with an out-of-range select; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else if (accept_s && oor_s && !bus.flush) begin
            sel_err_r <= 1'b1;
        end
    end

    assign bus.sel_err = sel_err_r;
`else
    assign bus.sel_err = 1'b0;
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = main_data_r;
    assign bus.out_sel   = main_sel_r;
endmodule
